// File: rtl/dp_ram_port_arb.sv
// dp_ram_port_arb: two-master round-robin arbiter in front of one RAM port.
// Each request is granted in the cycle it is raised. The response (rvalid/rdata)
// returns one cycle later to the master that was granted.
// Accesses to addresses at or above RAM_DEPTH are granted and answered with 0.
// They never enable the RAM.
// Optional macro DP_RAM_ARB_STATS_EN adds two saturating counters:
// conflict_cnt_o and access_cnt_o.
module dp_ram_port_arb #(
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic                  m0_we_i,
    input  logic [3:0]            m0_be_i,
    input  logic [31:0]           m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [31:0]           m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic                  m1_we_i,
    input  logic [3:0]            m1_be_i,
    input  logic [31:0]           m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [31:0]           m1_rdata_o,
    output logic                  ram_en_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    input  logic [31:0]           ram_rdata_i
`ifdef DP_RAM_ARB_STATS_EN
    ,
    output logic [31:0]           conflict_cnt_o,
    output logic [31:0]           access_cnt_o
`endif
);

    // RAM_DEPTH may equal 2**ADDR_WIDTH, so compare with one extra bit.
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic last_q;
    logic rvalid_q;
    logic owner_q;
    logic oob_q;

    logic gnt0;
    logic gnt1;
    logic any_gnt;
    logic in_range;
    logic [ADDR_WIDTH-1:0] sel_addr;

    // True when a word address falls inside the populated part of the RAM.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    // Round-robin grant: on a conflict the master that did not win last time wins now.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (m0_req_i && m1_req_i) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign any_gnt  = gnt0 | gnt1;
    assign sel_addr = gnt1 ? m1_addr_i : m0_addr_i;
    assign in_range = addr_in_range(sel_addr);

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign ram_en_o    = any_gnt & in_range;
    assign ram_addr_o  = sel_addr;
    assign ram_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;
    assign ram_we_o    = gnt1 ? m1_we_i    : m0_we_i;
    assign ram_be_o    = gnt1 ? m1_be_i    : m0_be_i;

    // Track the last winner and which master owns the response due next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= 1'b1;
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
            oob_q    <= 1'b0;
        end else begin
            rvalid_q <= any_gnt;
            if (any_gnt) begin
                last_q  <= gnt1;
                owner_q <= gnt1;
                oob_q   <= ~in_range;
            end
        end
    end

    // Gating with rst drops a response that is pending when reset arrives.
    assign m0_rvalid_o = rvalid_q & ~owner_q & ~rst;
    assign m1_rvalid_o = rvalid_q &  owner_q & ~rst;
    assign m0_rdata_o  = (m0_rvalid_o && !oob_q) ? ram_rdata_i : 32'h0;
    assign m1_rdata_o  = (m1_rvalid_o && !oob_q) ? ram_rdata_i : 32'h0;

`ifdef DP_RAM_ARB_STATS_EN
    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] conflict_cnt_q;
    logic [31:0] access_cnt_q;

    // Count conflict cycles and granted accesses.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt_q <= 32'h0;
            access_cnt_q   <= 32'h0;
        end else begin
            if (m0_req_i && m1_req_i) conflict_cnt_q <= sat_inc(conflict_cnt_q);
            if (any_gnt)              access_cnt_q   <= sat_inc(access_cnt_q);
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
    assign access_cnt_o   = access_cnt_q;
`endif

endmodule

// File: tb/tb_dp_ram_port_arb.sv
// Directed testbench for dp_ram_port_arb with a behavioural 1-cycle RAM model.
module tb_dp_ram_port_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [7:0]  m0_addr = '0, m1_addr = '0;
    logic [3:0]  m0_be = '0, m1_be = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic [3:0]  ram_be;
`ifdef DP_RAM_ARB_STATS_EN
    logic [31:0] conflict_cnt, access_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    always #5 clk = ~clk;

    dp_ram_port_arb #(.ADDR_WIDTH(8), .RAM_DEPTH(200)) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_addr_i(m0_addr), .m0_we_i(m0_we), .m0_be_i(m0_be),
        .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_addr_i(m1_addr), .m1_we_i(m1_we), .m1_be_i(m1_be),
        .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
`ifdef DP_RAM_ARB_STATS_EN
        , .conflict_cnt_o(conflict_cnt), .access_cnt_o(access_cnt)
`endif
    );

    // Behavioural RAM port: byte-enabled write, 1-cycle registered read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end else begin
                ram_rdata <= mem[ram_addr];
            end
        end
    end

    task automatic drive_m0(input logic req, input logic [7:0] a, input logic we,
                            input logic [3:0] be, input logic [31:0] wd);
        m0_req = req; m0_addr = a; m0_we = we; m0_be = be; m0_wdata = wd;
    endtask

    task automatic drive_m1(input logic req, input logic [7:0] a, input logic we,
                            input logic [3:0] be, input logic [31:0] wd);
        m1_req = req; m1_addr = a; m1_we = we; m1_be = be; m1_wdata = wd;
    endtask

    task automatic idle();
        drive_m0(1'b0, 8'h0, 1'b0, 4'h0, 32'h0);
        drive_m1(1'b0, 8'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_m0(1'b1, 8'h01, 1'b0, 4'hF, 32'h0);
        drive_m1(1'b1, 8'h02, 1'b0, 4'hF, 32'h0);
        #1;
        checks++; if (m0_gnt !== 1'b0) begin errors++; $display("FAIL rst_m0_gnt: got %b expected 0", m0_gnt); end
        checks++; if (m1_gnt !== 1'b0) begin errors++; $display("FAIL rst_m1_gnt: got %b expected 0", m1_gnt); end
        checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en: got %b expected 0", ram_en); end
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b expected 00", {m0_rvalid, m1_rvalid}); end
        checks++; if ((m0_rdata | m1_rdata) !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", m0_rdata | m1_rdata); end
        @(negedge clk); idle(); rst = 1'b0;
    endtask

    task automatic test_m0_write_read();
        @(negedge clk);
        drive_m0(1'b1, 8'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b expected 10", {m0_gnt, m1_gnt}); end
        checks++; if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b1, 8'h10}) begin errors++; $display("FAIL wr_ram_ctl: got en=%b we=%b addr=%h expected 1 1 10", ram_en, ram_we, ram_addr); end
        checks++; if (ram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_ram_wdata: got %h expected deadbeef", ram_wdata); end
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin errors++; $display("FAIL wr_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid}); end
        @(negedge clk);
        drive_m0(1'b1, 8'h10, 1'b0, 4'hF, 32'h0);
        #1;
        checks++; if ({m0_gnt, ram_en, ram_we} !== 3'b110) begin errors++; $display("FAIL rd_gnt: got gnt=%b en=%b we=%b expected 1 1 0", m0_gnt, ram_en, ram_we); end
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin errors++; $display("FAIL rd_rvalid: got %b expected 10", {m0_rvalid, m1_rvalid}); end
        checks++; if (m0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", m0_rdata); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin errors++; $display("FAIL rd_rvalid_drop: got %b expected 00", {m0_rvalid, m1_rvalid}); end
    endtask

    task automatic test_conflict();
        logic [1:0]  exp_gnt;
        logic [31:0] exp_data;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_m0(1'b1, 8'h01, 1'b0, 4'hF, 32'h0);
            drive_m1(1'b1, 8'h02, 1'b0, 4'hF, 32'h0);
            exp_gnt  = (i % 2 == 0) ? 2'b10 : 2'b01;
            exp_data = (i % 2 == 0) ? 32'h5A5A_5A01 : 32'h5A5A_5A02;
            #1;
            checks++; if ({m0_gnt, m1_gnt} !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {m0_gnt, m1_gnt}, exp_gnt); end
            @(posedge clk); #1;
            checks++; if ({m0_rvalid, m1_rvalid} !== exp_gnt) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b expected %b", i, {m0_rvalid, m1_rvalid}, exp_gnt); end
            checks++; if ((m0_rdata | m1_rdata) !== exp_data) begin errors++; $display("FAIL rr_rdata[%0d]: got %h expected %h", i, m0_rdata | m1_rdata, exp_data); end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_byte_enable();
        @(negedge clk);
        drive_m1(1'b1, 8'h05, 1'b1, 4'hF, 32'h1122_3344);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b01) begin errors++; $display("FAIL be_gnt: got %b expected 01", {m0_gnt, m1_gnt}); end
        @(negedge clk);
        drive_m1(1'b1, 8'h05, 1'b1, 4'h3, 32'h0000_AAAA);
        #1;
        checks++; if (ram_be !== 4'h3) begin errors++; $display("FAIL be_ram_be: got %h expected 3", ram_be); end
        @(negedge clk);
        drive_m1(1'b1, 8'h05, 1'b0, 4'hF, 32'h0);
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m1_rvalid} !== 2'b01) begin errors++; $display("FAIL be_rvalid: got %b expected 01", {m0_rvalid, m1_rvalid}); end
        checks++; if (m1_rdata !== 32'h1122_AAAA) begin errors++; $display("FAIL be_rdata: got %h expected 1122aaaa", m1_rdata); end
        @(negedge clk); idle();
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        drive_m0(1'b1, 8'hC8, 1'b1, 4'hF, 32'hFFFF_FFFF);
        #1;
        checks++; if ({m0_gnt, ram_en} !== 2'b10) begin errors++; $display("FAIL oob_wr: got gnt=%b en=%b expected 1 0", m0_gnt, ram_en); end
        @(posedge clk); #1;
        checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("FAIL oob_wr_rvalid: got %b expected 1", m0_rvalid); end
        @(negedge clk);
        drive_m0(1'b1, 8'hC8, 1'b0, 4'hF, 32'h0);
        #1;
        checks++; if ({m0_gnt, ram_en} !== 2'b10) begin errors++; $display("FAIL oob_rd: got gnt=%b en=%b expected 1 0", m0_gnt, ram_en); end
        @(posedge clk); #1;
        checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL oob_rd_resp: got rvalid=%b rdata=%h expected 1 0", m0_rvalid, m0_rdata); end
        checks++; if (mem[200] !== 32'h5A5A_5AC8) begin errors++; $display("FAIL oob_mem: got %h expected 5a5a5ac8", mem[200]); end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_drop();
        do_reset();
        drive_m0(1'b1, 8'h01, 1'b0, 4'hF, 32'h0);
        #1;
        checks++; if (m0_gnt !== 1'b1) begin errors++; $display("FAIL drop_gnt: got %b expected 1", m0_gnt); end
        @(posedge clk); #1;
        rst = 1'b1; idle();
        #1;
        checks++; if ({m0_rvalid, m0_rdata} !== {1'b0, 32'h0}) begin errors++; $display("FAIL drop_rvalid: got rvalid=%b rdata=%h expected 0 0", m0_rvalid, m0_rdata); end
        @(posedge clk); #1;
        checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL drop_rvalid_late: got %b expected 0", m0_rvalid); end
        @(negedge clk);
        rst = 1'b0;
        drive_m0(1'b1, 8'h01, 1'b0, 4'hF, 32'h0);
        drive_m1(1'b1, 8'h02, 1'b0, 4'hF, 32'h0);
        #1;
        checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin errors++; $display("FAIL drop_rr: got %b expected 10", {m0_gnt, m1_gnt}); end
        @(negedge clk); idle();
    endtask

`ifdef DP_RAM_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        checks++; if ({conflict_cnt, access_cnt} !== 64'h0) begin errors++; $display("FAIL stats_init: got %0d %0d expected 0 0", conflict_cnt, access_cnt); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive_m0(1'b1, 8'h01, 1'b0, 4'hF, 32'h0);
            drive_m1(1'b1, 8'h02, 1'b0, 4'hF, 32'h0);
            @(negedge clk);
        end
        idle(); drive_m0(1'b1, 8'h03, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        idle(); drive_m1(1'b1, 8'h04, 1'b0, 4'hF, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        checks++; if (conflict_cnt !== 32'd3) begin errors++; $display("FAIL stats_conflict: got %0d expected 3", conflict_cnt); end
        checks++; if (access_cnt !== 32'd5) begin errors++; $display("FAIL stats_access: got %0d expected 5", access_cnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({conflict_cnt, access_cnt} !== 64'h0) begin errors++; $display("FAIL stats_rst: got %0d %0d expected 0 0", conflict_cnt, access_cnt); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h5A5A_5A00 + 32'(i);
        ram_rdata = 32'h0;
        test_reset();
        test_m0_write_read();
        test_conflict();
        test_byte_enable();
        test_out_of_range();
        test_reset_drop();
`ifdef DP_RAM_ARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
